// File: rtl/sd_sched_pkg.sv
// sd_sched_pkg: shared types and default constants for the SD sector scheduler.
//   state_e  - scheduler FSM states
//   dir_e    - transfer direction (write = save, read = readback)
//   *_DEF    - default sector size and base sector addresses
package sd_sched_pkg;

  localparam int          SEC_WORDS_DEF    = 256;
  localparam logic [31:0] WR_BASE_ADDR_DEF = 32'd16384;
  localparam logic [31:0] RD_BASE_ADDR_DEF = 32'd16384;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_WAIT_DATA,
    S_WR_START,
    S_WR_WAIT_BH,
    S_WR_WAIT_BL,
    S_RD_WAIT_SPACE,
    S_RD_START,
    S_RD_WAIT_BH,
    S_RD_WAIT_BL,
    S_ERR
  } state_e;

endpackage

// File: rtl/sd_req_edge.sv
// sd_req_edge: two-flop rising-edge detector feeding a pending latch.
//   clk, rst  - clock, asynchronous active-high reset
//   req_i     - raw request level
//   block_i   - requester already in service; its edges are merged away
//   clr_i     - scheduler accepted the request this cycle
//   pend_o    - request pending
module sd_req_edge (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic block_i,
  input  logic clr_i,
  output logic pend_o
);

  logic req_s1_q, req_s2_q, pend_q, pend_d, edge_w;

  assign edge_w = req_s1_q & ~req_s2_q;

  // Clear wins over a coincident edge: that edge belongs to the image now starting.
  always_comb begin
    pend_d = (pend_q | (edge_w & ~block_i)) & ~clr_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      req_s1_q <= req_i;
      req_s2_q <= req_s1_q;
      pend_q   <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/sd_rw_sched.sv
// sd_rw_sched: shares one SPI SD controller between image save (write) and
// image readback (read). Each image becomes IMG_SECTORS single-sector commands,
// each gated on FIFO level so a sector never under/overflows its FIFO.
//   clk, rst                     - clock, asynchronous active-high reset
//   sd_init_done                 - card ready; gates arbitration and start pulses
//   save_req, read_req           - image requests (rising-edge detected)
//   wr_fifo_len, rd_fifo_len     - write FIFO words available / read FIFO words used
//   wr_busy, rd_busy             - controller busy per direction
//   wr/rd_start_en, wr/rd_sec_addr - one-cycle sector start and its sector address
//   wr/rd_image_done             - one-cycle pulse after the last sector of an image
//   sched_busy, sec_cnt          - not idle / sectors completed in current image
//   err_timeout                  - sticky: busy failed to rise within BUSY_TO cycles
module sd_rw_sched
  import sd_sched_pkg::*;
#(
  parameter int          SEC_WORDS     = SEC_WORDS_DEF,
  parameter int          IMG_SECTORS   = 1200,
  parameter logic [31:0] WR_BASE_ADDR  = WR_BASE_ADDR_DEF,
  parameter logic [31:0] RD_BASE_ADDR  = RD_BASE_ADDR_DEF,
  parameter int          RD_FIFO_DEPTH = 2048,
  parameter int          BUSY_TO       = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        save_req,
  input  logic        read_req,
  input  logic [9:0]  wr_fifo_len,
  input  logic [10:0] rd_fifo_len,
  input  logic        wr_busy,
  input  logic        rd_busy,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        wr_image_done,
  output logic        rd_image_done,
  output logic        sched_busy,
  output logic [10:0] sec_cnt,
  output logic        err_timeout
);

  localparam int          TW       = $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TO - 1);
  localparam logic [10:0] CNT_LAST = 11'(IMG_SECTORS - 1);

  state_e        state_q;
  dir_e          dir_q, last_q;
  logic [31:0]   wr_addr_q, rd_addr_q;
  logic [10:0]   cnt_q;
  logic [TW-1:0] tmo_q;
  logic          wr_start_q, rd_start_q, wr_done_q, rd_done_q, busy_q, err_q;

  logic pend_wr, pend_rd, can_arb, grant_wr, grant_rd;
  logic wr_in_svc, rd_in_svc, wr_data_ok, rd_space_ok;
  logic [11:0] rd_free;

  assign wr_in_svc = (state_q != S_IDLE) && (dir_q == DIR_WR);
  assign rd_in_svc = (state_q != S_IDLE) && (dir_q == DIR_RD);

  sd_req_edge u_wr_req (
    .clk(clk), .rst(rst), .req_i(save_req), .block_i(wr_in_svc),
    .clr_i(grant_wr), .pend_o(pend_wr)
  );

  sd_req_edge u_rd_req (
    .clk(clk), .rst(rst), .req_i(read_req), .block_i(rd_in_svc),
    .clr_i(grant_rd), .pend_o(pend_rd)
  );

  // Round-robin on a tie: serve the direction that was not served last.
  assign can_arb  = (state_q == S_IDLE) && sd_init_done;
  assign grant_wr = can_arb && pend_wr && (!pend_rd || last_q == DIR_RD);
  assign grant_rd = can_arb && pend_rd && (!pend_wr || last_q == DIR_WR);

  // Free space is computed one bit wider so an empty FIFO reads as DEPTH, not 0.
  assign rd_free     = 12'(RD_FIFO_DEPTH) - {1'b0, rd_fifo_len};
  assign wr_data_ok  = wr_fifo_len >= 10'(SEC_WORDS);
  assign rd_space_ok = rd_free >= 12'(SEC_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_WR;
      last_q     <= DIR_RD;
      wr_addr_q  <= WR_BASE_ADDR;
      rd_addr_q  <= RD_BASE_ADDR;
      cnt_q      <= '0;
      tmo_q      <= '0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_wr) begin
            state_q   <= S_WR_WAIT_DATA;
            dir_q     <= DIR_WR;
            last_q    <= DIR_WR;
            cnt_q     <= '0;
            wr_addr_q <= WR_BASE_ADDR;
            busy_q    <= 1'b1;
          end else if (grant_rd) begin
            state_q   <= S_RD_WAIT_SPACE;
            dir_q     <= DIR_RD;
            last_q    <= DIR_RD;
            cnt_q     <= '0;
            rd_addr_q <= RD_BASE_ADDR;
            busy_q    <= 1'b1;
          end
        end
        S_WR_WAIT_DATA: begin
          if (wr_data_ok && sd_init_done) begin
            wr_start_q <= 1'b1;
            state_q    <= S_WR_START;
          end
        end
        S_WR_START: begin
          tmo_q   <= '0;
          state_q <= S_WR_WAIT_BH;
        end
        S_WR_WAIT_BH: begin
          if (wr_busy) begin
            state_q <= S_WR_WAIT_BL;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WR_WAIT_BL: begin
          if (!wr_busy) begin
            cnt_q <= cnt_q + 11'd1;
            if (cnt_q == CNT_LAST) begin
              wr_done_q <= 1'b1;
              wr_addr_q <= WR_BASE_ADDR;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              wr_addr_q <= wr_addr_q + 32'd1;
              state_q   <= S_WR_WAIT_DATA;
            end
          end
        end
        S_RD_WAIT_SPACE: begin
          if (rd_space_ok && sd_init_done) begin
            rd_start_q <= 1'b1;
            state_q    <= S_RD_START;
          end
        end
        S_RD_START: begin
          tmo_q   <= '0;
          state_q <= S_RD_WAIT_BH;
        end
        S_RD_WAIT_BH: begin
          if (rd_busy) begin
            state_q <= S_RD_WAIT_BL;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RD_WAIT_BL: begin
          if (!rd_busy) begin
            cnt_q <= cnt_q + 11'd1;
            if (cnt_q == CNT_LAST) begin
              rd_done_q <= 1'b1;
              rd_addr_q <= RD_BASE_ADDR;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              rd_addr_q <= rd_addr_q + 32'd1;
              state_q   <= S_RD_WAIT_SPACE;
            end
          end
        end
        S_ERR: begin
          // Parked until reset; the image is abandoned.
        end
        default: begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign wr_start_en   = wr_start_q;
  assign rd_start_en   = rd_start_q;
  assign wr_sec_addr   = wr_addr_q;
  assign rd_sec_addr   = rd_addr_q;
  assign wr_image_done = wr_done_q;
  assign rd_image_done = rd_done_q;
  assign sched_busy    = busy_q;
  assign sec_cnt       = cnt_q;
  assign err_timeout   = err_q;

endmodule
